// File: rtl/hack_fetch_if.sv
// hack_fetch_if: ROM read port, jump redirect and decode handshake of the Hack fetch stage
interface hack_fetch_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16
);
  logic                  rom_en;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  jump;
  logic [ADDR_WIDTH-1:0] jump_addr;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  modport master (
    output rom_en, rom_addr, instr, instr_pc, instr_valid,
    input  rom_data, jump, jump_addr, instr_ready
  );
  modport slave (
    input  rom_en, rom_addr, instr, instr_pc, instr_valid,
    output rom_data, jump, jump_addr, instr_ready
  );
endinterface

// File: rtl/hack_fetch.sv
// hack_fetch: Hack CPU fetch stage with credit-based ROM issue and a 2-entry output buffer
module hack_fetch #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16,
  parameter int RESET_PC   = 0
) (
  input logic         clk,
  input logic         rst_n,
  hack_fetch_if.master bus
);
  localparam int EW = DATA_WIDTH + ADDR_WIDTH;
  logic [ADDR_WIDTH-1:0] fetchPc;
  logic                  inflight;
  logic [1:0]            count;
  logic [EW-1:0]         mem [2];
  logic                  deq;
  logic                  wr;
  logic                  wrIdx;
  assign deq             = bus.instr_valid & bus.instr_ready;
  assign wr              = inflight & !bus.jump;
  assign wrIdx           = count[1] | (count[0] & !deq);
  assign bus.rom_en      = rst_n & !bus.jump & (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, deq}));
  assign bus.rom_addr    = fetchPc;
  assign bus.instr_valid = count != 2'd0;
  assign {bus.instr, bus.instr_pc} = bus.instr_valid ? mem[0] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchPc  <= ADDR_WIDTH'(RESET_PC);
      inflight <= 1'b0;
      count    <= 2'd0;
    end else begin
      inflight <= bus.rom_en;
      fetchPc  <= bus.jump ? bus.jump_addr : bus.rom_en ? fetchPc + ADDR_WIDTH'(1) : fetchPc;
      count    <= bus.jump ? 2'd0 : count + {1'b0, wr} - {1'b0, deq};
    end
  end
  always_ff @(posedge clk) begin
    if (deq) mem[0] <= mem[1];
    if (wr) mem[wrIdx] <= {bus.rom_data, fetchPc - ADDR_WIDTH'(1)};
  end
endmodule
